// File: rtl/demux_rr_scheduler_if.sv
// demux_rr_scheduler_if: producer/consumer bus bundle for the
// round-robin demux scheduler (mask, input and output handshakes).
interface demux_rr_scheduler_if #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
);
  logic [N-1:0]    chanEnable;
  logic            inValid;
  logic            inReady;
  logic [W-1:0]    inData;
  logic [N-1:0]    outValid;
  logic [N-1:0]    outReady;
  logic [W-1:0]    outData;
  logic [LOGN-1:0] sel;
  logic            busy;

  modport slave (
    input  chanEnable, inValid, inData, outReady,
    output inReady, outValid, outData, sel, busy
  );

  modport master (
    output chanEnable, inValid, inData, outReady,
    input  inReady, outValid, outData, sel, busy
  );
endinterface

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: one input stream spread round-robin over N
// output lanes; one registered word, shared data bus, one-hot valid.
module demux_rr_scheduler #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_rr_scheduler_if.slave   bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] sel_q, sel_d;
  logic [LOGN-1:0] rr_q, rr_d;
  logic [W-1:0]    data_q, data_d;
  logic [LOGN-1:0] pick;
  logic [N-1:0]    out_valid;
  logic            any_en;
  logic            hold;
  logic            drain;
  logic            in_ready;
  logic            accept;

  function automatic logic [LOGN-1:0] wrap_idx(
    input logic [LOGN-1:0] base,
    input int              off
  );
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return LOGN'(s);
  endfunction

  // first enabled lane at or after rr_q, wrapping; nearest wins
  always_comb begin
    pick = rr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.chanEnable[wrap_idx(rr_q, k)]) begin
        pick = wrap_idx(rr_q, k);
      end
    end
  end

  assign any_en   = |bus.chanEnable;
  assign hold     = (state_q == HOLD);
  assign drain    = hold && bus.outReady[sel_q];
  assign in_ready = rst_n && any_en && (!hold || drain);
  assign accept   = bus.inValid && in_ready;

  // next state: load on accept, release on a lone drain
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    data_d  = data_q;
    if (accept) begin
      state_d = HOLD;
      data_d  = bus.inData;
      sel_d   = pick;
      rr_d    = (pick == LOGN'(N - 1)) ? '0 : pick + LOGN'(1);
    end else if (drain) begin
      state_d = IDLE;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
    end
  end

  // one-hot valid decoded straight from registered state
  always_comb begin
    out_valid = '0;
    if (hold) out_valid[sel_q] = 1'b1;
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid;
  assign bus.outData  = data_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = hold;

endmodule
